// File: rtl/seq_div.sv
// Sequential restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor -> 2*WIDTH-bit quotient, WIDTH-bit remainder.
// Latency: 2*WIDTH iterations after the accepted start (one per clock, or one per step pulse with SEQ_DIV_STEP_EN); divide-by-zero finishes one edge after start.
// Backpressure: none; start is accepted only in IDLE or DONE and ignored while busy.
//
// Optional feature macro: SEQ_DIV_STEP_EN -- when defined, an iteration happens only on edges with step=1;
// when undefined, step is ignored and one iteration happens every clock while busy.
//
// Ports:
//   clock        system clock, all state on the rising edge
//   reset_n      asynchronous active-low reset
//   start        request a division (sampled in IDLE/DONE only)
//   step         iteration enable (only meaningful with SEQ_DIV_STEP_EN)
//   dividend     unsigned dividend, captured on accepted start
//   divisor      unsigned divisor, captured on accepted start
//   quotient     registered result, updated only on entry to DONE
//   remainder    registered result, updated only on entry to DONE
//   busy         high while iterating
//   done         high when results are valid
//   div_by_zero  high in DONE when the captured divisor was zero
module seq_div #(
    parameter int WIDTH = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic               step,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic [2*WIDTH-1:0] quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero
);

    localparam int QW = 2 * WIDTH;
    localparam int CW = $clog2(QW + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [QW-1:0]    q_reg, q_nxt;
    logic [WIDTH:0]   r_reg, r_nxt;
    logic [WIDTH-1:0] dvsr_reg, dvsr_nxt;
    logic [CW-1:0]    cnt_reg, cnt_nxt;
    logic [QW-1:0]    quotient_nxt;
    logic [WIDTH-1:0] remainder_nxt;
    logic             dbz_nxt;

    logic             iter_en;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   r_trial;
    logic [QW-1:0]    q_sh;
    logic [WIDTH:0]   r_iter;
    logic [QW-1:0]    q_iter;

`ifdef SEQ_DIV_STEP_EN
    assign iter_en = step;
`else
    // step is kept on the port for a uniform top level but has no effect here.
    logic step_unused;
    assign step_unused = step;
    assign iter_en     = 1'b1;
`endif

    // One restoring iteration: shift the next dividend bit into the partial
    // remainder, then subtract the divisor back out if it fits.
    always_comb begin
        r_sh    = {r_reg[WIDTH-1:0], q_reg[QW-1]};
        q_sh    = {q_reg[QW-2:0], 1'b0};
        r_trial = r_sh - {1'b0, dvsr_reg};
        if (r_sh >= {1'b0, dvsr_reg}) begin
            r_iter = r_trial;
            q_iter = q_sh | {{(QW-1){1'b0}}, 1'b1};
        end else begin
            r_iter = r_sh;
            q_iter = q_sh;
        end
    end

    always_comb begin
        state_nxt     = state;
        q_nxt         = q_reg;
        r_nxt         = r_reg;
        dvsr_nxt      = dvsr_reg;
        cnt_nxt       = cnt_reg;
        quotient_nxt  = quotient;
        remainder_nxt = remainder;
        dbz_nxt       = div_by_zero;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = RUN;
                    dvsr_nxt  = divisor;
                    q_nxt     = dividend;
                    r_nxt     = '0;
                    cnt_nxt   = CW'(QW);
                    dbz_nxt   = 1'b0;
                end
            end
            RUN: begin
                if (dvsr_reg == '0) begin
                    // Zero divisor: skip iterations entirely, step is irrelevant.
                    state_nxt     = DONE;
                    quotient_nxt  = '1;
                    remainder_nxt = '0;
                    dbz_nxt       = 1'b1;
                end else if (iter_en) begin
                    q_nxt   = q_iter;
                    r_nxt   = r_iter;
                    cnt_nxt = cnt_reg - 1'b1;
                    if (cnt_reg == CW'(1)) begin
                        state_nxt     = DONE;
                        quotient_nxt  = q_iter;
                        remainder_nxt = r_iter[WIDTH-1:0];
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            q_reg       <= '0;
            r_reg       <= '0;
            dvsr_reg    <= '0;
            cnt_reg     <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_nxt;
            q_reg       <= q_nxt;
            r_reg       <= r_nxt;
            dvsr_reg    <= dvsr_nxt;
            cnt_reg     <= cnt_nxt;
            quotient    <= quotient_nxt;
            remainder   <= remainder_nxt;
            div_by_zero <= dbz_nxt;
        end
    end

    // Straight decodes of the state register, so both are glitch-free and
    // mutually exclusive.
    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_seq_div.sv
module tb_seq_div;

    localparam int WIDTH = 4;

    logic               clock;
    logic               reset_n;
    logic               start;
    logic               step;
    logic [2*WIDTH-1:0] dividend;
    logic [WIDTH-1:0]   divisor;
    logic [2*WIDTH-1:0] quotient;
    logic [WIDTH-1:0]   remainder;
    logic               busy;
    logic               done;
    logic               div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    seq_div #(.WIDTH(WIDTH)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .step        (step),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Full-rate division from IDLE/DONE: checks busy right after the start edge,
    // still busy after edge 2*WIDTH-1, and results exactly after edge 2*WIDTH.
    task automatic run_div(input string tag, input logic [7:0] dd, input logic [3:0] dv,
                           input logic [7:0] exp_q, input logic [3:0] exp_r);
        start    = 1'b1;
        dividend = dd;
        divisor  = dv;
        tick();
        start = 1'b0;
        chk({tag, " busy@0"}, 32'(busy), 32'd1);
        chk({tag, " done@0"}, 32'(done), 32'd0);
        repeat (7) tick();
        chk({tag, " busy@7"}, 32'(busy), 32'd1);
        tick();
        chk({tag, " done@8"}, 32'(done), 32'd1);
        chk({tag, " busy@8"}, 32'(busy), 32'd0);
        chk({tag, " quot"},   32'(quotient), 32'(exp_q));
        chk({tag, " rem"},    32'(remainder), 32'(exp_r));
        chk({tag, " dbz"},    32'(div_by_zero), 32'd0);
    endtask

    initial begin
        int done_edge;
        int exp_edge;

        reset_n  = 1'b0;
        start    = 1'b0;
        step     = 1'b1;
        dividend = '0;
        divisor  = '0;
        repeat (3) tick();

        chk("rst quot", 32'(quotient), 32'd0);
        chk("rst rem",  32'(remainder), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst dbz",  32'(div_by_zero), 32'd0);

        reset_n = 1'b1;
        tick();

        // Main case and boundary operands, back-to-back from DONE.
        run_div("200/7",  8'd200, 4'd7,  8'd28,  4'd4);
        run_div("255/1",  8'd255, 4'd1,  8'd255, 4'd0);
        run_div("5/9",    8'd5,   4'd9,  8'd0,   4'd5);
        run_div("255/15", 8'd255, 4'd15, 8'd17,  4'd0);

        // Divide by zero: done one edge after start.
        start    = 1'b1;
        dividend = 8'd13;
        divisor  = 4'd0;
        tick();
        start = 1'b0;
        chk("dz busy@0", 32'(busy), 32'd1);
        chk("dz quot held@0", 32'(quotient), 32'd17);
        tick();
        chk("dz done@1", 32'(done), 32'd1);
        chk("dz busy@1", 32'(busy), 32'd0);
        chk("dz flag",   32'(div_by_zero), 32'd1);
        chk("dz quot",   32'(quotient), 32'hFF);
        chk("dz rem",    32'(remainder), 32'd0);

        // Restart after divide by zero: flag clears on capture, old result held.
        start    = 1'b1;
        dividend = 8'd13;
        divisor  = 4'd3;
        tick();
        start = 1'b0;
        chk("13/3 dbz clr@0", 32'(div_by_zero), 32'd0);
        chk("13/3 quot held@0", 32'(quotient), 32'hFF);
        repeat (8) tick();
        chk("13/3 done", 32'(done), 32'd1);
        chk("13/3 quot", 32'(quotient), 32'd4);
        chk("13/3 rem",  32'(remainder), 32'd1);

        // Gated stepping: step high only on edges 3,6,9,...
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 4'd6;
        step     = 1'b0;
        tick();
        start     = 1'b0;
        done_edge = -1;
        for (int k = 1; k <= 40; k++) begin
            step = ((k % 3) == 0);
            tick();
            if (done && done_edge < 0) done_edge = k;
        end
        step = 1'b1;
`ifdef SEQ_DIV_STEP_EN
        exp_edge = 24;
`else
        exp_edge = 8;
`endif
        chk("step done edge", 32'(done_edge), 32'(exp_edge));
        chk("step quot", 32'(quotient), 32'd16);
        chk("step rem",  32'(remainder), 32'd4);

        // start during RUN must be ignored.
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 4'd7;
        tick();
        start = 1'b0;
        tick();
        tick();
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 4'd5;
        tick();
        start = 1'b0;
        chk("ign busy@3", 32'(busy), 32'd1);
        repeat (4) tick();
        chk("ign busy@7", 32'(busy), 32'd1);
        tick();
        chk("ign done@8", 32'(done), 32'd1);
        chk("ign quot", 32'(quotient), 32'd28);
        chk("ign rem",  32'(remainder), 32'd4);

        // Asynchronous reset in the middle of RUN.
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 4'd7;
        tick();
        start = 1'b0;
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        chk("arst busy", 32'(busy), 32'd0);
        chk("arst done", 32'(done), 32'd0);
        chk("arst quot", 32'(quotient), 32'd0);
        chk("arst rem",  32'(remainder), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        run_div("post-rst 13/3", 8'd13, 4'd3, 8'd4, 4'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
